// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle ARM-subset core
package mc_pkg;
    typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEMACC, ST_WB} state_t;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_t;
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] COND_AL = 4'he;
    localparam logic [3:0] COND_NV = 4'hf;
    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;
    // Conditions come in true/inverted pairs; bit 0 inverts, which also turns AL (14) into never (15).
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic r;
        r = c[3:1] == 3'd0 ? f[FZ] :
            c[3:1] == 3'd1 ? f[FC] :
            c[3:1] == 3'd2 ? f[FN] :
            c[3:1] == 3'd3 ? f[FV] :
            c[3:1] == 3'd4 ? f[FC] & ~f[FZ] :
            c[3:1] == 3'd5 ? f[FN] == f[FV] :
            c[3:1] == 3'd6 ? ~f[FZ] & (f[FN] == f[FV]) : 1'b1;
        return c[0] ? ~r : r;
    endfunction
endpackage

// File: rtl/mc_alu_flags.sv
// mc_alu_flags: combinational 32-bit ALU with NZCV outputs
// i_a, i_b: operands; i_op: ADD/SUB/AND/ORR; o_y: result; o_nzcv: flags (C=1 on SUB means no borrow)
module mc_alu_flags import mc_pkg::*; (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  alu_t        i_op,
    output logic [31:0] o_y,
    output logic [3:0]  o_nzcv
);
    logic [31:0] w_b;
    logic [32:0] w_sum;
    assign w_b    = i_op == ALU_SUB ? ~i_b : i_b;
    assign w_sum  = {1'b0, i_a} + {1'b0, w_b} + {32'b0, i_op == ALU_SUB};
    assign o_y    = i_op == ALU_AND ? i_a & i_b : i_op == ALU_ORR ? i_a | i_b : w_sum[31:0];
    assign o_nzcv = {o_y[31], o_y == 32'b0, w_sum[32], (i_a[31] == w_b[31]) && (o_y[31] != i_a[31])};
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: FSM-sequenced ARM-subset core sharing one ALU and one req/ack memory port
// clk, reset: clock and sync active-high reset; mem_*: unified memory handshake port
// dbg_addr/dbg_rdata: register view (15 = pc); pc, instr, flags, retire_count, illegal: status
module multicycle_datapath import mc_pkg::*; #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    input  logic [3:0]        dbg_addr,
    output logic [31:0]       dbg_rdata,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic [3:0]        flags,
    output logic [31:0]       retire_count,
    output logic              illegal
);
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_instr, r_a, r_b, r_alu, r_data, r_retire;
    logic [31:0] r_regs [15];
    logic [3:0]  r_flags;
    logic        r_cond;
    logic [1:0]  w_op;
    logic [3:0]  w_cmd, w_rn, w_rd, w_rm, w_rb, w_nzcv;
    logic [31:0] w_rn_val, w_rb_val, w_alu_b, w_y, w_wb;
    logic        w_ill, w_done, w_ack, w_retire, w_arith;
    alu_t        w_ctrl;
    assign w_op  = r_instr[27:26];
    assign w_cmd = r_instr[24:21];
    assign w_rn  = r_instr[19:16];
    assign w_rd  = r_instr[15:12];
    assign w_rm  = r_instr[3:0];
    assign w_rb  = w_op == OP_MEM ? w_rd : w_rm;
    // R15 reads as pc+4: pc already points past the instruction, so this is its address + 8.
    assign w_rn_val = w_rn == 4'hf ? r_pc + 32'd4 : r_regs[w_rn];
    assign w_rb_val = w_rb == 4'hf ? r_pc + 32'd4 : r_regs[w_rb];
    assign w_ill  = w_op == OP_ILL || (w_op == OP_DP && !(w_cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_CMP}));
    assign w_done = !r_cond || w_ill || w_op == OP_B || (w_op == OP_DP && w_cmd == CMD_CMP);
    assign w_alu_b = w_op == OP_MEM ? {20'b0, r_instr[11:0]} : r_instr[25] ? {24'b0, r_instr[7:0]} : r_b;
    assign w_ctrl = w_op == OP_MEM ? (r_instr[23] ? ALU_ADD : ALU_SUB) :
                    w_cmd == CMD_ADD ? ALU_ADD : w_cmd == CMD_AND ? ALU_AND :
                    w_cmd == CMD_ORR ? ALU_ORR : ALU_SUB;
    assign w_arith = w_ctrl == ALU_ADD || w_ctrl == ALU_SUB;
    assign w_wb  = w_op == OP_MEM ? r_data : r_alu;
    assign w_ack = mem_ack & mem_req;
    mc_alu_flags u_alu (.i_a(r_a), .i_b(w_alu_b), .i_op(w_ctrl), .o_y(w_y), .o_nzcv(w_nzcv));
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  w_next = w_ack ? ST_DECODE : ST_FETCH;
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = w_done ? ST_FETCH : w_op == OP_MEM ? ST_MEMACC : ST_WB;
            ST_MEMACC: w_next = !w_ack ? ST_MEMACC : r_instr[20] ? ST_WB : ST_FETCH;
            default:   w_next = ST_FETCH;
        endcase
    end
    // Every return to FETCH from a later state completes one instruction.
    assign w_retire = r_state != ST_FETCH && w_next == ST_FETCH;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_alu    <= '0;
            r_data   <= '0;
            r_flags  <= '0;
            r_cond   <= 1'b0;
            r_retire <= '0;
            for (int i = 0; i < 15; i++) r_regs[i] <= '0;
        end else begin
            r_retire <= r_retire + {31'b0, w_retire};
            case (r_state)
                ST_FETCH: if (w_ack) begin
                    r_instr <= mem_rdata;
                    r_pc    <= r_pc + 32'd4;
                end
                ST_DECODE: begin
                    r_a    <= w_rn_val;
                    r_b    <= w_rb_val;
                    r_cond <= cond_pass(r_instr[31:28], r_flags);
                end
                ST_EXEC: if (r_cond && !w_ill) begin
                    if (w_op == OP_B) r_pc <= r_pc + 32'd4 + {{6{r_instr[23]}}, r_instr[23:0], 2'b00};
                    else r_alu <= w_y;
                    if (w_op == OP_DP && (r_instr[20] || w_cmd == CMD_CMP))
                        r_flags <= w_arith ? w_nzcv : {w_nzcv[FN:FZ], r_flags[FC:FV]};
                end
                ST_MEMACC: if (w_ack) r_data <= mem_rdata;
                ST_WB: begin
                    if (w_rd == 4'hf) r_pc <= w_wb;
                    else r_regs[w_rd] <= w_wb;
                end
                default: ;
            endcase
        end
    end
    assign mem_req      = !reset && (r_state == ST_FETCH || r_state == ST_MEMACC);
    assign mem_we       = !reset && r_state == ST_MEMACC && !r_instr[20];
    assign mem_addr     = r_state == ST_FETCH ? r_pc[ADDR_W-1:0] : r_alu[ADDR_W-1:0];
    assign mem_wdata    = r_b;
    assign illegal      = !reset && r_state == ST_EXEC && r_cond && w_ill;
    assign dbg_rdata    = dbg_addr == 4'hf ? r_pc : r_regs[dbg_addr];
    assign pc           = r_pc;
    assign instr        = r_instr;
    assign flags        = r_flags;
    assign retire_count = r_retire;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: vector table, corner sequences and random program against an ISA-level model
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack = 1'b0, illegal;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata = '0, dbg_rdata, pc, instr, retire_count;
    logic [3:0]  dbg_addr = '0, flags;
    logic [31:0] mem [64];
    logic [31:0] m_mem [64];
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ret;
    logic [3:0]  m_fl;
    int n_chk = 0;
    int n_err = 0;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -MAXI - 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
        int          fw;
        int          dw;
        int          cyc;
        logic [3:0]  ridx;
        logic [31:0] rval;
        logic [3:0]  fl;
        logic [31:0] pc;
        logic [31:0] ret;
    } vec_t;
    vec_t tv [9];

    multicycle_datapath #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata), .pc(pc), .instr(instr), .flags(flags),
        .retire_count(retire_count), .illegal(illegal)
    );

    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] i, input logic [31:0] exp);
        dbg_addr = i;
        #1;
        chk($sformatf("r%0d", i), dbg_rdata, exp);
    endtask

    // Runs one instruction from its first FETCH negedge; memory answers fetch after fw and data after dw wait cycles.
    task automatic run_instr(input int fw, input int dw, output int cyc, output int ill_n, output logic stable,
                             output logic [31:0] daddr, output logic dwe, output logic [31:0] dwd);
        logic [31:0] prev;
        int xfer, cnt;
        bit seen;
        prev = retire_count; cyc = 0; ill_n = 0; xfer = 0; cnt = 0; seen = 0;
        stable = 1'b1; daddr = '0; dwe = 1'b0; dwd = '0;
        while (1) begin
            if (mem_req && xfer > 0) begin
                if (!seen) begin
                    daddr = {24'b0, mem_addr}; dwe = mem_we; dwd = mem_wdata; seen = 1;
                end else if (daddr != {24'b0, mem_addr} || dwe != mem_we || dwd != mem_wdata) stable = 1'b0;
            end
            if (mem_req && cnt >= (xfer == 0 ? fw : dw)) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr[7:2]];
                if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
                cnt = 0;
                xfer++;
            end else begin
                mem_ack = 1'b0;
                cnt = mem_req ? cnt + 1 : 0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (illegal) ill_n++;
            if (retire_count != prev || cyc >= 60) break;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_ill", {31'b0, illegal}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_req", {31'b0, mem_req}, 32'd1);
        chk("rel_we", {31'b0, mem_we}, 32'd0);
        chk("rel_addr", {24'b0, mem_addr}, 32'd0);
        chk("rel_ret", retire_count, 32'd0);
        chk("rel_pc", pc, 32'd0);
        chk("rel_flags", {28'b0, flags}, 32'd0);
        chk("rel_instr", instr, 32'd0);
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0; m_fl = '0; m_ret = '0;
    endtask

    function automatic logic holds(input logic [3:0] c);
        logic n, z, cy, v;
        {n, z, cy, v} = m_fl;
        case (c)
            4'd0: return z;
            4'd1: return !z;
            4'd2: return cy;
            4'd3: return !cy;
            4'd4: return n;
            4'd5: return !n;
            4'd6: return v;
            4'd7: return !v;
            4'd8: return cy && !z;
            4'd9: return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && n == v;
            4'd13: return z || n != v;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rv(input logic [3:0] i, input logic [31:0] ia);
        return i == 4'hf ? ia + 32'd8 : m_r[i];
    endfunction

    task automatic wr(input logic [3:0] i, input logic [31:0] v);
        if (i == 4'hf) m_pc = v;
        else m_r[i] = v;
    endtask

    // Instruction-level model: executes one instruction, reports base cycles, transfer count and illegality.
    task automatic model_step(output int base, output int nx, output bit ill);
        logic [31:0] w, ia, a, b, res, addr;
        logic [3:0] cmd;
        logic c, v, arith;
        longint s;
        w = m_mem[m_pc[7:2]]; ia = m_pc; m_pc = m_pc + 32'd4;
        base = 3; nx = 1; ill = 0; m_ret = m_ret + 32'd1;
        a = rv(w[19:16], ia);
        if (!holds(w[31:28])) return;
        case (w[27:26])
            2'b10: m_pc = ia + 32'd8 + {{6{w[23]}}, w[23:0], 2'b00};
            2'b11: ill = 1;
            2'b01: begin
                nx = 2;
                addr = w[23] ? a + {20'b0, w[11:0]} : a - {20'b0, w[11:0]};
                if (w[20]) begin
                    wr(w[15:12], m_mem[addr[7:2]]);
                    base = 5;
                end else begin
                    m_mem[addr[7:2]] = rv(w[15:12], ia);
                    base = 4;
                end
            end
            default: begin
                cmd = w[24:21];
                b = w[25] ? {24'b0, w[7:0]} : rv(w[3:0], ia);
                c = 1'b0; v = 1'b0; arith = 1'b0;
                case (cmd)
                    4'b0100: begin
                        res = a + b;
                        c = (longint'(a) + longint'(b)) >= 64'h1_0000_0000;
                        s = longint'($signed(a)) + longint'($signed(b));
                        v = s > MAXI || s < MINI;
                        arith = 1'b1;
                    end
                    4'b0010, 4'b1010: begin
                        res = a - b;
                        c = a >= b;
                        s = longint'($signed(a)) - longint'($signed(b));
                        v = s > MAXI || s < MINI;
                        arith = 1'b1;
                    end
                    4'b0000: res = a & b;
                    4'b1100: res = a | b;
                    default: begin
                        ill = 1;
                        return;
                    end
                endcase
                if (w[20] || cmd == 4'b1010) m_fl = {res[31], res == 32'b0, arith ? c : m_fl[1], arith ? v : m_fl[0]};
                if (cmd != 4'b1010) begin
                    wr(w[15:12], res);
                    base = 4;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w, o;
        int r, k;
        w = $urandom;
        r = $urandom_range(0, 9);
        w[31:28] = ($urandom_range(0, 3) != 0) ? 4'he : 4'($urandom_range(0, 15));
        w[27:26] = r < 5 ? 2'b00 : r < 8 ? 2'b01 : r < 9 ? 2'b10 : 2'b11;
        if (r < 5 && $urandom_range(0, 7) != 0) begin
            k = $urandom_range(0, 4);
            w[24:21] = k == 0 ? 4'b0000 : k == 1 ? 4'b0010 : k == 2 ? 4'b0100 : k == 3 ? 4'b1100 : 4'b1010;
        end
        if (r == 8) begin
            o = 32'($urandom_range(0, 16)) - 32'd8;
            w[23:0] = o[23:0];
        end
        return w;
    endfunction

    initial begin
        int cyc, ill_n, base, nx, fw, dw;
        bit ill;
        logic stable, dwe;
        logic [31:0] daddr, dwd;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        tv[0] = '{32'h00, 32'hE2801005, 0, 0, 4, 4'd1, 32'd5, 4'b0000, 32'h04, 32'd1};
        tv[1] = '{32'h04, 32'hE2512005, 1, 0, 5, 4'd2, 32'd0, 4'b0110, 32'h08, 32'd2};
        tv[2] = '{32'h08, 32'h1A000003, 0, 0, 3, 4'd2, 32'd0, 4'b0110, 32'h0C, 32'd3};
        tv[3] = '{32'h0C, 32'hEA000007, 0, 0, 3, 4'd1, 32'd5, 4'b0110, 32'h30, 32'd4};
        tv[4] = '{32'h38, 32'hEAFFFFF8, 0, 0, 3, 4'd3, 32'd5, 4'b0110, 32'h20, 32'd7};
        tv[5] = '{32'h20, 32'hEAFFFFFE, 0, 0, 3, 4'd1, 32'd5, 4'b0110, 32'h20, 32'd8};
        tv[6] = '{32'h20, 32'hEAFFFFFE, 0, 0, 3, 4'd1, 32'd5, 4'b0110, 32'h20, 32'd9};
        tv[7] = '{32'h20, 32'hEAFFFFFE, 2, 0, 5, 4'd1, 32'd5, 4'b0110, 32'h20, 32'd10};
        tv[8] = '{32'h24, 32'h00000000, 0, 0, 0, 4'd0, 32'd0, 4'b0000, 32'h00, 32'd0};
        for (int k = 0; k < 8; k++) mem[tv[k].addr[7:2]] = tv[k].ins;
        mem[12] = 32'hE5801010;
        mem[13] = 32'hE5903010;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                run_instr(0, 0, cyc, ill_n, stable, daddr, dwe, dwd);
                chk("str_cyc", cyc, 32'd4);
                chk("str_we", {31'b0, dwe}, 32'd1);
                chk("str_addr", daddr, 32'h10);
                chk("str_wdata", dwd, 32'd5);
                chk("str_mem", mem[4], 32'd5);
                run_instr(0, 3, cyc, ill_n, stable, daddr, dwe, dwd);
                chk("ldr_cyc", cyc, 32'd8);
                chk("ldr_stable", {31'b0, stable}, 32'd1);
                chk("ldr_we", {31'b0, dwe}, 32'd0);
                chk("ldr_addr", daddr, 32'h10);
                chk_reg(4'd3, 32'd5);
                chk("ldr_ret", retire_count, 32'd6);
            end
            run_instr(tv[k].fw, tv[k].dw, cyc, ill_n, stable, daddr, dwe, dwd);
            chk($sformatf("v%0d_cyc", k), cyc, tv[k].cyc);
            chk($sformatf("v%0d_ill", k), ill_n, 32'd0);
            chk($sformatf("v%0d_pc", k), pc, tv[k].pc);
            chk($sformatf("v%0d_flags", k), {28'b0, flags}, {28'b0, tv[k].fl});
            chk($sformatf("v%0d_ret", k), retire_count, tv[k].ret);
            chk_reg(tv[k].ridx, tv[k].rval);
        end

        do_reset();
        mem[0] = 32'hE2801005;
        mem[1] = 32'hE5901010;
        mem[4] = 32'h77;
        run_instr(0, 0, cyc, ill_n, stable, daddr, dwe, dwd);
        chk_reg(4'd1, 32'd5);
        mem_ack = 1'b1; mem_rdata = mem[1];
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_req", {31'b0, mem_req}, 32'd1);
        chk("wait_addr", {24'b0, mem_addr}, 32'h10);
        @(negedge clk);
        chk("wait_req2", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_req", {31'b0, mem_req}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk("abort_fetch", {31'b0, mem_req}, 32'd1);
        chk("abort_addr", {24'b0, mem_addr}, 32'd0);
        chk("abort_pc", pc, 32'd0);
        chk("abort_instr", instr, 32'd0);
        chk("abort_ret", retire_count, 32'd0);
        chk_reg(4'd1, 32'd0);
        @(negedge clk);
        mem[0] = 32'hEC000000;
        run_instr(0, 0, cyc, ill_n, stable, daddr, dwe, dwd);
        chk("ill_pulse", ill_n, 32'd1);
        chk("ill_cyc", cyc, 32'd3);
        chk("ill_ret", retire_count, 32'd1);
        chk("ill_pc", pc, 32'd4);

        do_reset();
        for (int i = 0; i < 64; i++) begin
            mem[i] = gen();
            m_mem[i] = mem[i];
        end
        for (int n = 0; n < 400; n++) begin
            fw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            model_step(base, nx, ill);
            run_instr(fw, dw, cyc, ill_n, stable, daddr, dwe, dwd);
            chk($sformatf("rnd%0d_cyc", n), cyc, base + fw + (nx == 2 ? dw : 0));
            chk($sformatf("rnd%0d_ill", n), ill_n, {31'b0, ill});
            chk($sformatf("rnd%0d_ret", n), retire_count, m_ret);
            chk($sformatf("rnd%0d_flags", n), {28'b0, flags}, {28'b0, m_fl});
            for (int i = 0; i < 16; i++) chk_reg(4'(i), i == 15 ? m_pc : m_r[i]);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
